// File: rtl/wb_regfile_pkg.sv
// Shared constants for the write-back stage: MEM/WB control layout,
// write-back source encodings and load funct3 codes.
package wb_regfile_pkg;

  localparam int CTRL_W        = 12;
  localparam int CTRL_REGWRITE = 0;
  localparam int CTRL_WBSEL    = 1;  // two bits, [2:1]
  localparam int CTRL_FUNCT3   = 3;  // three bits, [5:3]
  localparam int CTRL_VALID    = 6;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_IMM = 2'b10,
    WB_PC4 = 2'b11
  } wbsel_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef struct packed {
    logic       valid;
    logic [2:0] funct3;
    wbsel_e     wbsel;
    logic       regwrite;
  } ctrl_t;

  function automatic ctrl_t decode_ctrl(input logic [CTRL_W-1:0] raw);
    ctrl_t c;
    c.valid    = raw[CTRL_VALID];
    c.funct3   = raw[CTRL_FUNCT3 +: 3];
    c.wbsel    = wbsel_e'(raw[CTRL_WBSEL +: 2]);
    c.regwrite = raw[CTRL_REGWRITE];
    return c;
  endfunction

endpackage

// File: rtl/wb_regfile_load_extend.sv
// Picks the addressed byte/halfword out of an aligned memory word and
// sign- or zero-extends it; unknown funct3 codes pass the full word.
module wb_regfile_load_extend
  import wb_regfile_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] raw,
  input  logic [1:0]      off,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (off)
      2'd0:    byte_sel = raw[7:0];
      2'd1:    byte_sel = raw[15:8];
      2'd2:    byte_sel = raw[23:16];
      default: byte_sel = raw[31:24];
    endcase
  end

  // Halfword loads ignore off[0]: misaligned halves are the memory side's problem.
  assign half_sel = off[1] ? raw[31:16] : raw[15:0];

  always_comb begin
    case (funct3)
      F3_LB:   ext = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LBU:  ext = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LH:   ext = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_LHU:  ext = {{(XLEN-16){1'b0}}, half_sel};
      default: ext = raw;
    endcase
  end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: selects the result, commits it to the register file,
// serves two bypassed read ports and counts retired instructions.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int NREG = 32,
  parameter int XLEN = 32,
  parameter int CNTW = 64
) (
  input  logic                    clkIn,
  input  logic                    resetIn,
  input  logic [$clog2(NREG)-1:0] rdIn,
  input  logic [XLEN-1:0]         retAddrIn,
  input  logic [XLEN-1:0]         ImmIn,
  input  logic [XLEN-1:0]         ResultIn,
  input  logic [XLEN-1:0]         memRdataIn,
  input  logic [CTRL_W-1:0]       ctrlIn,
  input  logic [$clog2(NREG)-1:0] rs1Addr,
  input  logic [$clog2(NREG)-1:0] rs2Addr,
  output logic [XLEN-1:0]         rs1Data,
  output logic [XLEN-1:0]         rs2Data,
  output logic                    wbEn,
  output logic [$clog2(NREG)-1:0] wbRd,
  output logic [XLEN-1:0]         wbData,
  output logic [CNTW-1:0]         instretOut
);

  localparam int AW    = $clog2(NREG);
  localparam int NPORT = 2;

  ctrl_t           ctrl;
  logic [XLEN-1:0] load_val;
  logic [XLEN-1:0] wb_data;
  logic            wb_en;
  logic            ctrl_unused;
  logic [XLEN-1:0] regs [NREG];
  logic [CNTW-1:0] instret;

  assign ctrl        = decode_ctrl(ctrlIn);
  assign ctrl_unused = ^ctrlIn[CTRL_W-1:CTRL_VALID+1];

  wb_regfile_load_extend #(.XLEN(XLEN)) u_load_extend (
    .raw    (memRdataIn),
    .off    (ResultIn[1:0]),
    .funct3 (ctrl.funct3),
    .ext    (load_val)
  );

  always_comb begin
    case (ctrl.wbsel)
      WB_ALU:  wb_data = ResultIn;
      WB_MEM:  wb_data = load_val;
      WB_IMM:  wb_data = ImmIn;
      default: wb_data = retAddrIn;
    endcase
  end

  assign wb_en  = ctrl.valid & ctrl.regwrite & (rdIn != '0);
  assign wbEn   = wb_en;
  assign wbRd   = rdIn;
  assign wbData = wb_data;

  // x0 is never written, so its array slot stays at its reset value.
  always_ff @(posedge clkIn or posedge resetIn) begin
    if (resetIn) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wb_en) begin
      regs[rdIn] <= wb_data;
    end
  end

  // Read ports: x0 forced to zero, then same-cycle write-through, then array.
  logic [NPORT-1:0][AW-1:0]   rs_addr;
  logic [NPORT-1:0][XLEN-1:0] rs_data;

  assign rs_addr = {rs2Addr, rs1Addr};

  for (genvar p = 0; p < NPORT; p++) begin : g_rd
    assign rs_data[p] = (rs_addr[p] == '0)                ? '0      :
                        (wb_en && (rdIn == rs_addr[p]))   ? wb_data :
                                                            regs[rs_addr[p]];
  end

  assign rs1Data = rs_data[0];
  assign rs2Data = rs_data[1];

  always_ff @(posedge clkIn or posedge resetIn) begin
    if (resetIn)         instret <= '0;
    else if (ctrl.valid) instret <= instret + CNTW'(1);
  end

  assign instretOut = instret;

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: directed vector table, hand-written reset
// sequences and randomized traffic checked against a behavioural model.
module tb_wb_regfile;

  logic        clkIn = 1'b0;
  logic        resetIn;
  logic [4:0]  rdIn, rs1Addr, rs2Addr, wbRd;
  logic [31:0] retAddrIn, ImmIn, ResultIn, memRdataIn;
  logic [11:0] ctrlIn;
  logic [31:0] rs1Data, rs2Data, wbData;
  logic        wbEn;
  logic [63:0] instretOut;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_regs [32];
  logic [63:0] m_cnt;

  wb_regfile dut (
    .clkIn(clkIn), .resetIn(resetIn), .rdIn(rdIn), .retAddrIn(retAddrIn),
    .ImmIn(ImmIn), .ResultIn(ResultIn), .memRdataIn(memRdataIn), .ctrlIn(ctrlIn),
    .rs1Addr(rs1Addr), .rs2Addr(rs2Addr), .rs1Data(rs1Data), .rs2Data(rs2Data),
    .wbEn(wbEn), .wbRd(wbRd), .wbData(wbData), .instretOut(instretOut)
  );

  always #5 clkIn = ~clkIn;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] ret, imm, res, mem;
    logic [11:0] ctrl;
    logic [4:0]  a1, a2;
    logic [31:0] e_rs1, e_rs2, e_wbdata;
    logic        e_wben;
    logic [63:0] e_cnt;
  } vec_t;

  vec_t tbl [14];

  function automatic logic [11:0] mk(input logic v, input logic rw,
                                     input logic [1:0] sel, input logic [2:0] f3);
    return {5'b0, v, f3, sel, rw};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: loads computed by shift/mask arithmetic straight from the ISA rules.
  function automatic logic [31:0] m_load(input logic [31:0] w, input int off, input logic [2:0] f3);
    int unsigned b, h;
    b = (w >> (8 * off)) & 32'hFF;
    h = (w >> (16 * (off / 2))) & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 128) ? b - 256 : b;
      3'b100:  return b;
      3'b001:  return (h >= 32768) ? h - 65536 : h;
      3'b101:  return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] m_wbdata();
    case (ctrlIn[2:1])
      2'd0:    return ResultIn;
      2'd1:    return m_load(memRdataIn, int'(ResultIn % 4), ctrlIn[5:3]);
      2'd2:    return ImmIn;
      default: return retAddrIn;
    endcase
  endfunction

  function automatic logic m_wben();
    return ctrlIn[6] && ctrlIn[0] && (rdIn != 0);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 0) return 0;
    if (m_wben() && rdIn == a) return m_wbdata();
    return m_regs[a];
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 0;
    m_cnt = 0;
  endtask

  // Model state after the coming rising edge.
  task automatic m_commit();
    if (m_wben()) m_regs[rdIn] = m_wbdata();
    if (ctrlIn[6]) m_cnt = m_cnt + 1;
  endtask

  task automatic drive(input logic [4:0] rd, input logic [31:0] ret, input logic [31:0] imm,
                       input logic [31:0] res, input logic [31:0] mem, input logic [11:0] ctrl,
                       input logic [4:0] a1, input logic [4:0] a2);
    @(negedge clkIn);
    rdIn = rd; retAddrIn = ret; ImmIn = imm; ResultIn = res;
    memRdataIn = mem; ctrlIn = ctrl; rs1Addr = a1; rs2Addr = a2;
    #1;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, " rs1Data"}, rs1Data, m_read(rs1Addr));
    chk({tag, " rs2Data"}, rs2Data, m_read(rs2Addr));
    chk({tag, " wbEn"}, wbEn, m_wben());
    chk({tag, " wbData"}, wbData, m_wbdata());
    chk({tag, " wbRd"}, wbRd, rdIn);
    chk({tag, " instret"}, instretOut, m_cnt);
  endtask

  initial begin
    localparam logic [31:0] M = 32'h80FF7F01;
    tbl[0]  = '{5'd3,  0, 0, 32'h12345678, 0, mk(1,1,2'd0,3'd0), 5'd3, 5'd0,
                32'h12345678, 32'h0, 32'h12345678, 1'b1, 64'd0};
    tbl[1]  = '{5'd0,  0, 0, 0, 0, mk(0,0,2'd0,3'd0), 5'd3, 5'd5,
                32'h12345678, 32'h0, 32'h0, 1'b0, 64'd1};
    tbl[2]  = '{5'd10, 0, 0, 32'h3, M, mk(1,1,2'd1,3'b000), 5'd10, 5'd3,
                32'hFFFFFF80, 32'h12345678, 32'hFFFFFF80, 1'b1, 64'd1};
    tbl[3]  = '{5'd11, 0, 0, 32'h103, M, mk(1,1,2'd1,3'b100), 5'd11, 5'd10,
                32'h00000080, 32'hFFFFFF80, 32'h00000080, 1'b1, 64'd2};
    tbl[4]  = '{5'd12, 0, 0, 32'h2, M, mk(1,1,2'd1,3'b001), 5'd12, 5'd11,
                32'hFFFF80FF, 32'h00000080, 32'hFFFF80FF, 1'b1, 64'd3};
    tbl[5]  = '{5'd13, 0, 0, 32'h1, M, mk(1,1,2'd1,3'b101), 5'd13, 5'd12,
                32'h00007F01, 32'hFFFF80FF, 32'h00007F01, 1'b1, 64'd4};
    tbl[6]  = '{5'd14, 0, 0, 32'h3, M, mk(1,1,2'd1,3'b010), 5'd14, 5'd13,
                32'h80FF7F01, 32'h00007F01, 32'h80FF7F01, 1'b1, 64'd5};
    tbl[7]  = '{5'd0,  0, 0, 32'hDEADBEEF, 0, mk(1,1,2'd0,3'd0), 5'd0, 5'd14,
                32'h0, 32'h80FF7F01, 32'hDEADBEEF, 1'b0, 64'd6};
    tbl[8]  = '{5'd20, 0, 32'hABCDE000, 0, 0, mk(1,1,2'd2,3'd0), 5'd20, 5'd0,
                32'hABCDE000, 32'h0, 32'hABCDE000, 1'b1, 64'd7};
    tbl[9]  = '{5'd21, 32'h104, 0, 0, 0, mk(1,1,2'd3,3'd0), 5'd21, 5'd20,
                32'h00000104, 32'hABCDE000, 32'h00000104, 1'b1, 64'd8};
    tbl[10] = '{5'd22, 0, 0, 32'h777, 0, mk(0,1,2'd0,3'd0), 5'd22, 5'd21,
                32'h0, 32'h00000104, 32'h777, 1'b0, 64'd9};
    tbl[11] = '{5'd0,  0, 0, 0, 0, mk(0,0,2'd0,3'd0), 5'd22, 5'd0,
                32'h0, 32'h0, 32'h0, 1'b0, 64'd9};
    tbl[12] = '{5'd15, 0, 0, 32'h2, 32'hCAFEF00D, mk(1,1,2'd1,3'b011), 5'd15, 5'd15,
                32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D, 1'b1, 64'd9};
    tbl[13] = '{5'd16, 0, 0, 32'h11, 0, 12'hF80 | mk(1,1,2'd0,3'd0), 5'd16, 5'd15,
                32'h11, 32'hCAFEF00D, 32'h11, 1'b1, 64'd10};

    // Reset then read
    resetIn = 1'b1;
    rdIn = 0; retAddrIn = 0; ImmIn = 0; ResultIn = 0; memRdataIn = 0;
    ctrlIn = 0; rs1Addr = 5'd5; rs2Addr = 5'd31;
    m_reset();
    repeat (2) @(posedge clkIn);
    @(negedge clkIn);
    resetIn = 1'b0;
    #1;
    chk("reset rs1Data", rs1Data, 0);
    chk("reset rs2Data", rs2Data, 0);
    chk("reset instret", instretOut, 0);

    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].rd, tbl[i].ret, tbl[i].imm, tbl[i].res, tbl[i].mem, tbl[i].ctrl,
            tbl[i].a1, tbl[i].a2);
      chk($sformatf("vec%0d rs1Data", i), rs1Data, tbl[i].e_rs1);
      chk($sformatf("vec%0d rs2Data", i), rs2Data, tbl[i].e_rs2);
      chk($sformatf("vec%0d wbEn", i), wbEn, tbl[i].e_wben);
      chk($sformatf("vec%0d wbData", i), wbData, tbl[i].e_wbdata);
      chk($sformatf("vec%0d instret", i), instretOut, tbl[i].e_cnt);
      m_commit();
    end

    // All table loads must have landed in the array
    drive(0, 0, 0, 0, 0, 12'h0, 5'd10, 5'd11);
    chk("array x10", rs1Data, 32'hFFFFFF80);
    chk("array x11", rs2Data, 32'h00000080);
    chk("array instret", instretOut, 64'd11);
    m_commit();
    drive(0, 0, 0, 0, 0, 12'h0, 5'd14, 5'd0);
    chk("array x14", rs1Data, 32'h80FF7F01);
    m_commit();

    for (int n = 0; n < 400; n++) begin
      drive(5'($urandom_range(0, 7)), $urandom, $urandom, $urandom, $urandom,
            12'($urandom), 5'($urandom_range(0, 7)),
            (n % 4 == 0) ? 5'($urandom) : 5'($urandom_range(0, 7)));
      chk_model($sformatf("rand%0d", n));
      m_commit();
    end

    // Async reset mid-cycle
    drive(5'd7, 0, 0, 32'h55, 0, mk(1,1,2'd0,3'd0), 5'd0, 5'd0);
    m_commit();
    drive(5'd0, 0, 0, 0, 0, 12'h0, 5'd7, 5'd7);
    chk("pre-reset x7", rs1Data, 32'h55);
    #1 resetIn = 1'b1;
    #1;
    chk("mid reset x7", rs1Data, 0);
    chk("mid reset instret", instretOut, 0);
    resetIn = 1'b0;
    m_reset();
    #1;
    chk("post reset x7", rs2Data, 0);
    m_commit();

    // First edge after release accepts a write
    drive(5'd8, 0, 0, 32'hA5A5A5A5, 0, mk(1,1,2'd0,3'd0), 5'd0, 5'd0);
    m_commit();
    drive(5'd0, 0, 0, 0, 0, 12'h0, 5'd8, 5'd7);
    chk("after reset x8", rs1Data, 32'hA5A5A5A5);
    chk("after reset x7", rs2Data, 0);
    chk("after reset instret", instretOut, 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Write-back end of the MEM/WB boundary. Consumes the MEM/WB register outputs plus the load data returned by data memory.
- Selects and extends the write-back value and commits it to the 32x32 architectural register file.
- Serves the two decode-stage read ports with same-cycle write-through bypass.
- Maintains a retired-instruction counter.

Parameters:
- NREG, 32, number of architectural registers (x0 hardwired to zero)
- XLEN, 32, data width
- CNTW, 64, retire counter width

Ports:
- clkIn  in  1  clock, all state updates on rising edge
- resetIn  in  1  asynchronous, active-high reset
- rdIn  in  5  destination register from MEM/WB
- retAddrIn  in  32  PC+4 for JAL/JALR
- ImmIn  in  32  immediate, used for LUI
- ResultIn  in  32  ALU result; also the load byte address
- memRdataIn  in  32  raw aligned word from data memory
- ctrlIn  in  12  MEM/WB control bits
- rs1Addr  in  5  read port 1 address
- rs2Addr  in  5  read port 2 address
- rs1Data  out  32  read port 1 data, combinational
- rs2Data  out  32  read port 2 data, combinational
- wbEn  out  1  write-back strobe this cycle, combinational, for the forwarding unit
- wbRd  out  5  write-back destination, combinational
- wbData  out  32  write-back value, combinational
- instretOut  out  64  retired-instruction count, registered

Behaviour:
- ctrlIn fields:
  - [0] RegWrite
  - [2:1] WbSel: 00 ALU result, 01 load data, 10 Imm, 11 retAddr
  - [5:3] load funct3
  - [6] Valid, meaning a real instruction and not a bubble
  - [11:7] reserved, ignored
- Load extraction, with off = ResultIn[1:0]:
  - funct3 000 LB: byte at off, sign-extended
  - funct3 100 LBU: byte at off, zero-extended
  - funct3 001 LH: halfword at off[1] (off[0] ignored), sign-extended
  - funct3 101 LHU: halfword at off[1] (off[0] ignored), zero-extended
  - funct3 010 and all other codes: full word, off ignored
- wbEn = Valid & RegWrite & (rdIn != 0).
- wbRd = rdIn. wbData = the selected value, regardless of wbEn.
- Write: on a rising edge with wbEn=1, regs[rdIn] <= wbData. Writes to x0 are never performed.
- Read: rsXData is 0 when rsXAddr == 0. Otherwise, if wbEn and wbRd == rsXAddr, it returns wbData (write-through bypass, so there is no one-cycle WB-to-ID hazard). Otherwise it returns regs[rsXAddr].
- Both read ports may address the same register and may both bypass in the same cycle.
- Retire counter: increments by 1 on each edge with Valid=1, independent of RegWrite. It wraps from all-ones to 0 silently.
- Reset, asynchronous, effective immediately even mid-cycle:
  - All regs go to 0 and instretOut goes to 0.
  - Combinational outputs follow their inputs during reset; reads return 0 from the cleared array.
  - The first write is accepted on the first rising edge after resetIn deasserts.
- Latency: a write is visible at read ports in the same cycle via bypass, and from the array on the following cycle.
- No stall input. The MEM/WB register inserts bubbles by clearing Valid.

Decomposition:
- Shared package holds:
  - the ctrl bit-position constants (CTRL_REGWRITE, CTRL_WBSEL, CTRL_FUNCT3, CTRL_VALID)
  - the WbSel encodings (WB_ALU, WB_MEM, WB_IMM, WB_PC4)
  - the load funct3 encodings (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU)
- One sub-module is natural: load_extend (combinational; raw word, offset, funct3 -> extended 32-bit value).
- The mux, array, bypass logic and counter stay in wb_regfile.

Test Plan:
1. Reset then read: assert resetIn for 2 cycles; after release, rs1Addr=5 and rs2Addr=31 -> both data outputs 0, instretOut=0.
2. ALU write-through: ctrl Valid=1, RegWrite=1, WbSel=00, rdIn=3, ResultIn=0x12345678, rs1Addr=3 in the same cycle -> rs1Data=0x12345678. Next cycle with a bubble -> rs1Data still 0x12345678 from the array, instretOut=1.
3. Loads with memRdataIn=0x80FF7F01:
   - LB off=3 -> 0xFFFFFF80
   - LBU off=3 -> 0x00000080
   - LH off=2 -> 0xFFFF80FF
   - LHU off=1 -> 0x00007F01
   - LW -> 0x80FF7F01
   Each value must land in the target register.
4. x0 protection: RegWrite=1, rdIn=0, ResultIn=0xDEADBEEF -> wbEn=0, rs1Addr=0 returns 0, instretOut still increments.
5. Select paths: WbSel=10 with ImmIn=0xABCDE000 writes 0xABCDE000; WbSel=11 with retAddrIn=0x00000104 writes 0x104. A Valid=0 bubble with RegWrite=1 -> no write, counter unchanged.
6. Async reset mid-operation: after writing x7=0x55, pulse resetIn between clock edges -> rs1Data for x7 drops to 0 before the next edge, and instretOut=0.
